// File: rtl/mem_port.sv
// mem_port: memory access port for the multicycle core.
// Owns MAR/MDR, loads them from the core databus and runs single-beat
// read/write transactions on the external memory bus with a req/ack handshake.
//
// Optional feature macro: MEM_PORT_TIMEOUT_EN
//   defined   : ack watchdog. After TIMEOUT REQ cycles without ack the
//               transaction is abandoned and sticky err is set.
//   undefined : REQ waits for ack indefinitely, err tied to 0.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   load_mar, load_mdr        load MAR / MDR from bus_in (IDLE only)
//   mem_rd, mem_wr            start read / write (write wins if both)
//   bus_in                    core databus
//   mar_out, mdr_out          register contents
//   mdr_valid                 MDR holds read data or loaded data
//   busy, err                 transaction in flight / last one timed out
//   mem_req, mem_we           bus request and direction (registered)
//   mem_addr, mem_wdata       MAR / MDR driven to the bus
//   mem_ack, mem_rdata        bus completion and read data
module mem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_mar,
    input  logic              load_mdr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              mdr_valid,
    output logic              busy,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              vld_q;
    logic              we_q;

`ifdef MEM_PORT_TIMEOUT_EN
    logic       err_q;
    logic [7:0] wait_cnt;
    // Fires when this no-ack REQ cycle is the TIMEOUT-th one.
    logic       expire;
    assign expire = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= '0;
            vld_q    <= 1'b0;
            we_q     <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            err_q    <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Loads land first so a same-cycle start uses the new values.
                    if (load_mar) mar <= bus_in[ADDR_W-1:0];
                    if (load_mdr) begin
                        mdr   <= bus_in;
                        vld_q <= 1'b1;
                    end
                    if (mem_wr) begin
                        state <= REQ;
                        we_q  <= 1'b1;
`ifdef MEM_PORT_TIMEOUT_EN
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
`endif
                    end else if (mem_rd) begin
                        // A read invalidates MDR even if load_mdr wrote it this cycle.
                        state <= REQ;
                        we_q  <= 1'b0;
                        vld_q <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    // Ack wins over a same-cycle timeout.
                    if (mem_ack) begin
                        state <= IDLE;
                        if (!we_q) begin
                            mdr   <= mem_rdata;
                            vld_q <= 1'b1;
                        end
                    end
`ifdef MEM_PORT_TIMEOUT_EN
                    else if (expire) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mar_out   = mar;
    assign mdr_out   = mdr;
    assign mdr_valid = vld_q;
    assign busy      = (state == REQ);
    assign mem_req   = (state == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
`ifdef MEM_PORT_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
